// File: rtl/rr_invert_mux.sv
// Round-robin N-channel mux with per-channel optional inversion feeding a
// single registered valid/ready output stage.
module rr_invert_mux #(
    parameter int N_CH = 4,
    parameter int W    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_CH-1:0]           in_valid,
    output logic [N_CH-1:0]           in_ready,
    input  logic [N_CH*W-1:0]         in_data,
    input  logic [N_CH-1:0]           inv_mask,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [W-1:0]              out_data,
    output logic [$clog2(N_CH)-1:0]   out_chan
);

    localparam int CW = $clog2(N_CH);

    logic [CW-1:0]   ptr;
    logic            load;
    logic [N_CH-1:0] grant;
    logic            gnt_any;
    logic [CW-1:0]   gnt_idx;
    logic [W-1:0]    sel_data;
    logic [W-1:0]    ch_data [N_CH];

    for (genvar i = 0; i < N_CH; i++) begin : g_split
        assign ch_data[i] = in_data[i*W +: W];
    end

    // Valid/ready: a word moves on channel i when in_valid[i] & in_ready[i] at
    // the rising edge; the output word leaves when out_valid & out_ready. A
    // producer must hold valid and data until accepted; ready never reaches a
    // channel that is not valid, and nothing is accepted while rst is high.
    assign load = (!out_valid || out_ready) && !rst;

    // Search starts just past the last winner so every valid channel is reached
    // within N_CH grants; a lone requester wraps back onto itself.
    always_comb begin
        logic [CW-1:0] idx;
        grant    = '0;
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        sel_data = '0;
        idx      = '0;
        for (int k = 1; k <= N_CH; k++) begin
            idx = CW'((int'(ptr) + k) % N_CH);
            if (!gnt_any && in_valid[idx]) begin
                gnt_any      = 1'b1;
                gnt_idx      = idx;
                grant[idx]   = 1'b1;
                sel_data     = ch_data[idx] ^ {W{inv_mask[idx]}};
            end
        end
    end

    assign in_ready = grant & {N_CH{load}};

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            ptr       <= CW'(N_CH - 1);
        end else if (load) begin
            if (gnt_any) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_chan  <= gnt_idx;
                ptr       <= gnt_idx;
            end else begin
                // Empty pop: drop valid, keep the last word and pointer.
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_invert_mux.sv
// Self-checking bench for rr_invert_mux: directed scenarios plus a random
// phase, checked against a scoreboard fed by the driven stimulus.
module tb_rr_invert_mux;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int CW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      in_valid;
    logic [N-1:0]      in_ready;
    logic [N*W-1:0]    in_data;
    logic [N-1:0]      inv_mask;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      out_data;
    logic [CW-1:0]     out_chan;

    int n_checks = 0;
    int n_fail   = 0;

    logic [CW+W-1:0] exp_q[$];
    bit              m_valid = 1'b0;
    int              m_ptr   = N - 1;
    bit              m_known = 1'b0;

    rr_invert_mux #(.N_CH(N), .W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .inv_mask (inv_mask),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_chan (out_chan)
    );

    // clock / reset block
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_grant(input logic [N-1:0] v, input int p);
        for (int k = 1; k <= N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // One clock cycle: inputs are already driven; check, update model, advance.
    task automatic step();
        int           g;
        bit           ld;
        logic [N-1:0] exp_rdy;
        logic [W-1:0] d;
        #1;
        if (m_known) begin
            check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
            if (m_valid && exp_q.size() > 0)
                check("out_word", {22'd0, out_chan, out_data}, {22'd0, exp_q[0]});
        end
        ld = !rst && (!m_valid || out_ready);
        g  = model_grant(in_valid, m_ptr);
        exp_rdy = (ld && g >= 0) ? (N'(1) << g) : '0;
        if (m_known || rst)
            check("in_ready", {28'd0, in_ready}, {28'd0, exp_rdy});
        if (rst) begin
            exp_q.delete();
            m_valid = 1'b0;
            m_ptr   = N - 1;
            m_known = 1'b1;
        end else begin
            if (m_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (ld) begin
                if (g >= 0) begin
                    d = in_data[g*W +: W] ^ {W{inv_mask[g]}};
                    exp_q.push_back({CW'(g), d});
                    m_ptr   = g;
                    m_valid = 1'b1;
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) step();
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        inv_mask  = '0;
        out_ready = 1'b1;
        @(negedge clk);

        // Reset with every channel requesting; channel 0 must win first.
        in_valid = 4'b1111;
        in_data  = {8'h44, 8'h33, 8'h22, 8'h11};
        do_reset(2);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        step();
        check("first_chan", {30'd0, out_chan}, 32'd0);
        check("first_data", {24'd0, out_data}, 32'h11);

        // Inversion on a lone channel, then the same channel again uninverted.
        do_reset(1);
        in_valid = 4'b0100;
        in_data  = {8'h00, 8'hA5, 8'h00, 8'h00};
        inv_mask = 4'b0100;
        step();
        check("inv_data", {24'd0, out_data}, 32'h5A);
        check("inv_chan", {30'd0, out_chan}, 32'd2);
        inv_mask = 4'b0000;
        step();
        check("noinv_data", {24'd0, out_data}, 32'hA5);
        check("noinv_chan", {30'd0, out_chan}, 32'd2);

        // Round-robin at full rate.
        do_reset(1);
        in_valid  = 4'b1111;
        in_data   = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("rr_valid", {31'd0, out_valid}, 32'd1);
            check("rr_chan", {30'd0, out_chan}, i % N);
        end

        // Backpressure: held word (ch1) stays, no ready; release serves ch2 at once.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            inv_mask = N'($urandom_range(0, 15));
            step();
            check("bp_chan", {30'd0, out_chan}, 32'd1);
            check("bp_data", {24'd0, out_data}, 32'hB1);
            check("bp_ready", {28'd0, in_ready}, 32'd0);
        end
        inv_mask  = '0;
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", {28'd0, in_ready}, 32'b0100);
        step();
        check("bp_release_chan", {30'd0, out_chan}, 32'd2);

        // Wrap and skip: only ch1 and ch3 valid.
        do_reset(1);
        in_valid = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            step();
            check("skip_valid", {31'd0, out_valid}, 32'd1);
            check("skip_chan", {30'd0, out_chan}, (i % 2 == 0) ? 32'd1 : 32'd3);
        end

        // Reset mid-stream while a word is held under backpressure.
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        step();
        do_reset(1);
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        step();
        check("midrst_chan", {30'd0, out_chan}, 32'd0);

        // Random traffic against the scoreboard.
        for (int i = 0; i < 400; i++) begin
            in_valid  = N'($urandom_range(0, 15));
            in_data   = $urandom;
            inv_mask  = N'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
